// File: rtl/order_tx_pkg.sv
// Shared constants, state encoding, entry layout and helpers for the order tx framer.
package order_tx_pkg;

  localparam logic [7:0]  SOF_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN_BASE   = 7;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam int unsigned ENTRY_W          = 48;

  // Framer state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_SIDE = 3'd3;
  localparam logic [2:0] ST_TS   = 3'd4;
  localparam logic [2:0] ST_CRC  = 3'd5;

  // One buffered order decision
  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  side;
    logic [31:0] ts;
  } order_entry_t;

  // CRC-8, MSB first, no reflection, no final xor
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  // Timestamp byte by index, index 0 is the most significant byte
  function automatic logic [7:0] ts_byte(input logic [31:0] ts, input logic [1:0] idx);
    logic [31:0] sh;
    sh = ts << {idx, 3'b000};
    return sh[31:24];
  endfunction

endpackage

// File: rtl/order_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy count.
module order_tx_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CW-1:0]    count_nxt_c;

  // A push into a full FIFO only lands when a pop frees a slot in the same cycle
  always_comb begin
    do_pop_c    = pop && !empty;
    do_push_c   = push && (!full || do_pop_c);
    count_nxt_c = count + CW'(do_push_c) - CW'(do_pop_c);
  end

  assign rdata = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  // Pointers, count and flags reflecting post-update occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

endmodule

// File: rtl/order_tx_framer.sv
// Buffers order decisions and serializes each one into a byte-framed message.
// Optional CRC-8 trailer byte enabled by defining ORDER_TX_CRC8_EN.
module order_tx_framer
  import order_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SOF_BYTE   = SOF_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  tx_addr0,
  input  logic [7:0]  tx_buysell0,
  input  logic [31:0] tx_timestamp0,
  input  logic        tx_dv0,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_busy,
  output logic        fifo_full,
  output logic [15:0] drop_count
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0]  TS_LAST = 2'(FRAME_LEN_BASE - 4);

  logic [2:0]      state_q, state_nxt;
  logic [1:0]      ts_idx_q, ts_idx_nxt;
  logic [7:0]      byte_nxt;
  logic            valid_nxt;
  order_entry_t    hold_q;
  order_entry_t    push_entry_c;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push_req_c;
  logic            pop_c;
  logic            accept_c;
  logic            drop_c;
`ifdef ORDER_TX_CRC8_EN
  logic [7:0]      crc_q;
  logic [7:0]      crc_upd_c;
`endif

  // Hold decisions are filtered out before the FIFO
  always_comb begin
    push_req_c   = tx_dv0 && (tx_buysell0 != 8'd0);
    push_entry_c = '{addr: tx_addr0, side: tx_buysell0, ts: tx_timestamp0};
    accept_c     = byte_valid && byte_ready;
    drop_c       = push_req_c && (fifo_count == CW'(FIFO_DEPTH)) && !pop_c;
  end

  order_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req_c),
    .pop     (pop_c),
    .wdata   (push_entry_c),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef ORDER_TX_CRC8_EN
  assign crc_upd_c = crc8_byte(crc_q, byte_out);

  // Running CRC over accepted payload bytes, cleared between frames
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_q <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      crc_q <= 8'd0;
    end else if (accept_c && (state_q == ST_ADDR || state_q == ST_SIDE || state_q == ST_TS)) begin
      crc_q <= crc_upd_c;
    end
  end
`endif

  // Next state and next registered byte; outputs hold while the MAC stalls
  always_comb begin
    state_nxt  = state_q;
    ts_idx_nxt = ts_idx_q;
    byte_nxt   = byte_out;
    valid_nxt  = byte_valid;
    pop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byte_nxt  = 8'd0;
        valid_nxt = 1'b0;
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          state_nxt = ST_SOF;
          byte_nxt  = SOF_BYTE;
          valid_nxt = 1'b1;
        end
      end
      ST_SOF: begin
        if (accept_c) begin
          state_nxt = ST_ADDR;
          byte_nxt  = hold_q.addr;
        end
      end
      ST_ADDR: begin
        if (accept_c) begin
          state_nxt = ST_SIDE;
          byte_nxt  = hold_q.side;
        end
      end
      ST_SIDE: begin
        if (accept_c) begin
          state_nxt  = ST_TS;
          ts_idx_nxt = 2'd0;
          byte_nxt   = ts_byte(hold_q.ts, 2'd0);
        end
      end
      ST_TS: begin
        if (accept_c) begin
          if (ts_idx_q == TS_LAST) begin
`ifdef ORDER_TX_CRC8_EN
            state_nxt = ST_CRC;
            byte_nxt  = crc_upd_c;
`else
            state_nxt = ST_IDLE;
            byte_nxt  = 8'd0;
            valid_nxt = 1'b0;
`endif
          end else begin
            ts_idx_nxt = ts_idx_q + 2'd1;
            byte_nxt   = ts_byte(hold_q.ts, ts_idx_q + 2'd1);
          end
        end
      end
      ST_CRC: begin
`ifdef ORDER_TX_CRC8_EN
        if (accept_c) begin
          state_nxt = ST_IDLE;
          byte_nxt  = 8'd0;
          valid_nxt = 1'b0;
        end
`else
        state_nxt = ST_IDLE;
        byte_nxt  = 8'd0;
        valid_nxt = 1'b0;
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
        byte_nxt  = 8'd0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State register with registered stream outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ts_idx_q   <= 2'd0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      frame_busy <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      ts_idx_q   <= ts_idx_nxt;
      byte_out   <= byte_nxt;
      byte_valid <= valid_nxt;
      frame_busy <= (state_nxt != ST_IDLE);
    end
  end

  // Holding register for the entry being framed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (pop_c) begin
      hold_q <= order_entry_t'(fifo_rdata);
    end
  end

  // Saturating count of decisions lost to a full FIFO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count <= 16'd0;
    end else if (drop_c && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_order_tx_framer.sv
// Directed bench for order_tx_framer; honours ORDER_TX_CRC8_EN for frame length.
module tb_order_tx_framer;

`ifdef ORDER_TX_CRC8_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif

  typedef logic [7:0] frame_t [8];

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  side;
    logic [31:0] ts;
    bit          toggle;
    bit          expect_frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  tx_addr0;
  logic [7:0]  tx_buysell0;
  logic [31:0] tx_timestamp0;
  logic        tx_dv0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_busy;
  logic        fifo_full;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_q [$];

  logic       stall_pend = 1'b0;
  logic [7:0] prev_byte  = 8'd0;

  order_tx_framer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_addr0      (tx_addr0),
    .tx_buysell0   (tx_buysell0),
    .tx_timestamp0 (tx_timestamp0),
    .tx_dv0        (tx_dv0),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .frame_busy    (frame_busy),
    .fifo_full     (fifo_full),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Bit-serial CRC-8 reference, poly 0x07, init 0
  function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic frame_t build_frame(input logic [7:0] a, input logic [7:0] s, input logic [31:0] t);
    frame_t f;
    logic [7:0] crc;
    f[0] = 8'hA5; f[1] = a; f[2] = s;
    f[3] = t[31:24]; f[4] = t[23:16]; f[5] = t[15:8]; f[6] = t[7:0];
    crc = 8'h00;
    for (int k = 1; k < 7; k++) crc = crc_model(crc, f[k]);
    f[7] = crc;
    return f;
  endfunction

  // Stream monitor: records accepted bytes and checks stability across stalls
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (stall_pend) begin
        check("stall_valid", 32'(byte_valid), 32'd1);
        check("stall_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (byte_valid && byte_ready) rx_q.push_back(byte_out);
    end
    stall_pend = (reset_n === 1'b1) && byte_valid && !byte_ready;
    prev_byte  = byte_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_dv(input logic [7:0] a, input logic [7:0] s, input logic [31:0] t);
    tx_addr0 = a; tx_buysell0 = s; tx_timestamp0 = t; tx_dv0 = 1'b1;
    step();
    tx_dv0 = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input bit toggle);
    for (int c = 0; c < 400 && rx_q.size() < n; c++) begin
      if (toggle) byte_ready = ~byte_ready;
      else byte_ready = 1'b1;
      step();
    end
    byte_ready = 1'b1;
    check("rx_count", 32'(rx_q.size()), 32'(n));
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic compare_frame(input string name, input int base, input frame_t f);
    for (int k = 0; k < FL; k++) begin
      if (base + k < rx_q.size()) check(name, 32'(rx_q[base + k]), 32'(f[k]));
      else check({name, "_missing"}, 32'hDEAD, 32'(f[k]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs [6];
    frame_t f;
    logic [15:0] saved_drops;
    bit found;

    vecs[0] = '{8'h00, 8'h02, 32'h0000_0001, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 8'h02, 32'h0000_0001, 1'b1, 1'b1};
    vecs[2] = '{8'h12, 8'h01, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h03, 32'h80FF_0102, 1'b1, 1'b1};
    vecs[4] = '{8'h34, 8'h00, 32'h1234_5678, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 8'h01, 32'h0000_0000, 1'b1, 1'b1};

    reset_n = 1'b0; tx_addr0 = 8'd0; tx_buysell0 = 8'd0; tx_timestamp0 = 32'd0;
    tx_dv0 = 1'b0; byte_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    step();

    // Latency and back-to-back beats with ready held high
    f = build_frame(8'h00, 8'h02, 32'h0000_0001);
    pulse_dv(8'h00, 8'h02, 32'h0000_0001);
    check("lat_n1_valid", 32'(byte_valid), 32'd0);
    step();
    check("lat_n2_valid", 32'(byte_valid), 32'd1);
    check("lat_n2_sof", 32'(byte_out), 32'hA5);
    check("lat_n2_busy", 32'(frame_busy), 32'd1);
    for (int k = 1; k < FL; k++) begin
      step();
      check("beat_valid", 32'(byte_valid), 32'd1);
      check("beat_byte", 32'(byte_out), 32'(f[k]));
    end
    step();
    check("gap_valid", 32'(byte_valid), 32'd0);
    check("gap_busy", 32'(frame_busy), 32'd0);
    for (int c = 0; c < 3; c++) step();
    rx_q.delete();

    // Table of single decisions, some with a toggling ready
    for (int v = 0; v < 6; v++) begin
      rx_q.delete();
      saved_drops = drop_count;
      byte_ready = 1'b1;
      pulse_dv(vecs[v].addr, vecs[v].side, vecs[v].ts);
      if (vecs[v].expect_frame) begin
        wait_bytes(FL, vecs[v].toggle);
        compare_frame("vec_byte", 0, build_frame(vecs[v].addr, vecs[v].side, vecs[v].ts));
      end else begin
        for (int c = 0; c < 20; c++) step();
        check("hold_no_bytes", 32'(rx_q.size()), 32'd0);
        check("hold_drops", 32'(drop_count), 32'(saved_drops));
        check("hold_busy", 32'(frame_busy), 32'd0);
        check("hold_full", 32'(fifo_full), 32'd0);
      end
    end

    // Overflow: six decisions against a stalled MAC
    rx_q.delete();
    byte_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tx_addr0 = 8'(i); tx_buysell0 = 8'h01; tx_timestamp0 = 32'(i); tx_dv0 = 1'b1;
      step();
    end
    tx_dv0 = 1'b0;
    check("ovf_drops", 32'(drop_count), 32'd1);
    check("ovf_full", 32'(fifo_full), 32'd1);
    step();
    check("ovf_sof", 32'(byte_out), 32'hA5);
    check("ovf_valid", 32'(byte_valid), 32'd1);
    wait_bytes(5 * FL, 1'b0);
    for (int i = 1; i <= 5; i++) compare_frame("ovf_frame", (i - 1) * FL, build_frame(8'(i), 8'h01, 32'(i)));
    check("ovf_full_after", 32'(fifo_full), 32'd0);
    check("ovf_drops_after", 32'(drop_count), 32'd1);
    check("ovf_idle", 32'(frame_busy), 32'd0);

    // Reset in the middle of timestamp byte 1
    rx_q.delete();
    byte_ready = 1'b1;
    pulse_dv(8'h55, 8'h02, 32'h1122_3344);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (byte_valid && byte_out == 8'h22) found = 1'b1;
      else step();
    end
    check("mid_found_ts1", 32'(found), 32'd1);
    reset_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(byte_valid), 32'd0);
    check("mid_rst_busy", 32'(frame_busy), 32'd0);
    check("mid_rst_drops", 32'(drop_count), 32'd0);
    check("mid_rst_byte", 32'(byte_out), 32'd0);
    reset_n = 1'b1;
    rx_q.delete();
    for (int c = 0; c < 4; c++) step();
    check("mid_no_partial", 32'(rx_q.size()), 32'd0);
    pulse_dv(8'h66, 8'h01, 32'hCAFE_F00D);
    wait_bytes(FL, 1'b0);
    compare_frame("post_rst_frame", 0, build_frame(8'h66, 8'h01, 32'hCAFE_F00D));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
